// File: rtl/uart_rx_tx_fifo.sv
// Parametrised UART: baud tick generator, TX serialiser, 16x oversampled RX with FIFO and sticky errors.
// Latency: RX word visible one cycle after its stop bit is sampled; TX line follows state with no extra delay.
// Backpressure: uart_tx_ready low while a frame is in flight; RX FIFO drops new words when full (overflow flag).

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign out_vld = (count != '0);
    assign pop     = out_vld && out_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign in_rdy  = (count != CW'(DEPTH)) || pop;
    assign push    = in_vld && in_rdy;
    assign out_dat = out_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_rx_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_FREQ   = 18_432_000,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_int,
    input  logic                 uart_reset,
    input  logic [1:0]           freq_control,
    input  logic [DATA_BITS-1:0] uart_tx_data,
    input  logic                 uart_tx_valid,
    output logic                 uart_tx_ready,
    output logic                 uart_tx_d_out,
    input  logic                 uart_rx_d_in,
    output logic [DATA_BITS-1:0] uart_rx_data,
    output logic                 uart_rx_valid,
    input  logic                 uart_rx_ready,
    output logic                 uart_rx_frame_err,
    output logic                 uart_rx_parity_err,
    output logic                 uart_rx_overflow,
    input  logic                 uart_err_clear
);
    function automatic int calc_div(input int baud);
        return (CLK_FREQ + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

    localparam int   DIV0   = calc_div(9600);
    localparam int   DIV1   = calc_div(19200);
    localparam int   DIV2   = calc_div(57600);
    localparam int   DIV3   = calc_div(115200);
    localparam int   CNT_W  = $clog2(DIV0 + 1);
    localparam int   OS_W   = $clog2(OVERSAMPLE);
    localparam int   BIT_W  = $clog2(DATA_BITS);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    // ---------------- baud tick ----------------
    logic [1:0]       freq_q;
    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] tick_cnt;
    logic             freq_chg;
    logic             tick;

    always_comb begin
        div_m1 = CNT_W'(DIV0 - 1);
        case (freq_control)
            2'b00: div_m1 = CNT_W'(DIV0 - 1);
            2'b01: div_m1 = CNT_W'(DIV1 - 1);
            2'b10: div_m1 = CNT_W'(DIV2 - 1);
            2'b11: div_m1 = CNT_W'(DIV3 - 1);
            default: div_m1 = CNT_W'(DIV0 - 1);
        endcase
    end

    assign freq_chg = (freq_control != freq_q);
    assign tick     = (tick_cnt == div_m1) && !freq_chg;

    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            freq_q   <= freq_control;
            tick_cnt <= '0;
        end else begin
            freq_q <= freq_control;
            if (freq_chg || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t            tx_state, tx_state_nxt;
    logic [OS_W-1:0]      tx_os_cnt, tx_os_cnt_nxt;
    logic [BIT_W-1:0]     tx_bit_cnt, tx_bit_cnt_nxt;
    logic [DATA_BITS-1:0] tx_shreg, tx_shreg_nxt;
    logic                 tx_par, tx_par_nxt;
    logic                 tx_os_end;

    assign tx_os_end = tick && (tx_os_cnt == OS_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            tx_state   <= TX_IDLE;
            tx_os_cnt  <= '0;
            tx_bit_cnt <= '0;
            tx_shreg   <= '0;
            tx_par     <= 1'b0;
        end else begin
            tx_state   <= tx_state_nxt;
            tx_os_cnt  <= tx_os_cnt_nxt;
            tx_bit_cnt <= tx_bit_cnt_nxt;
            tx_shreg   <= tx_shreg_nxt;
            tx_par     <= tx_par_nxt;
        end
    end

    always_comb begin
        tx_state_nxt   = tx_state;
        tx_os_cnt_nxt  = tx_os_cnt;
        tx_bit_cnt_nxt = tx_bit_cnt;
        tx_shreg_nxt   = tx_shreg;
        tx_par_nxt     = tx_par;
        uart_tx_ready  = 1'b0;
        uart_tx_d_out  = 1'b1;
        if (tick) begin
            tx_os_cnt_nxt = tx_os_end ? '0 : tx_os_cnt + OS_W'(1);
        end
        case (tx_state)
            TX_IDLE: begin
                uart_tx_ready  = 1'b1;
                tx_os_cnt_nxt  = '0;
                tx_bit_cnt_nxt = '0;
                if (uart_tx_valid) begin
                    tx_shreg_nxt = uart_tx_data;
                    tx_par_nxt   = (^uart_tx_data) ^ PAR_ODD;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                uart_tx_d_out = 1'b0;
                if (tx_os_end) begin
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                uart_tx_d_out = tx_shreg[0];
                if (tx_os_end) begin
                    tx_shreg_nxt   = tx_shreg >> 1;
                    tx_bit_cnt_nxt = tx_bit_cnt + BIT_W'(1);
                    if (tx_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        tx_state_nxt = PAR_EN ? TX_PARITY : TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                uart_tx_d_out = tx_par;
                if (tx_os_end) begin
                    tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_os_end) begin
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    rx_state_t            rx_state, rx_state_nxt;
    logic [OS_W-1:0]      rx_os_cnt, rx_os_cnt_nxt;
    logic [BIT_W-1:0]     rx_bit_cnt, rx_bit_cnt_nxt;
    logic [DATA_BITS-1:0] rx_shreg, rx_shreg_nxt;
    logic                 rx_sync1, rx_sync2, rx_prev;
    logic                 rx_fall;
    logic                 rx_os_end;
    logic                 rx_half_end;
    logic                 rx_push;
    logic                 frame_set;
    logic                 parity_set;
    logic                 overflow_set;
    logic                 fifo_in_rdy;

    assign rx_fall     = rx_prev && !rx_sync2;
    assign rx_os_end   = tick && (rx_os_cnt == OS_W'(OVERSAMPLE - 1));
    assign rx_half_end = tick && (rx_os_cnt == OS_W'(OVERSAMPLE / 2 - 1));

    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            rx_sync1   <= 1'b1;
            rx_sync2   <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_os_cnt  <= '0;
            rx_bit_cnt <= '0;
            rx_shreg   <= '0;
        end else begin
            rx_sync1   <= uart_rx_d_in;
            rx_sync2   <= rx_sync1;
            rx_prev    <= rx_sync2;
            rx_state   <= rx_state_nxt;
            rx_os_cnt  <= rx_os_cnt_nxt;
            rx_bit_cnt <= rx_bit_cnt_nxt;
            rx_shreg   <= rx_shreg_nxt;
        end
    end

    always_comb begin
        rx_state_nxt   = rx_state;
        rx_os_cnt_nxt  = rx_os_cnt;
        rx_bit_cnt_nxt = rx_bit_cnt;
        rx_shreg_nxt   = rx_shreg;
        rx_push        = 1'b0;
        frame_set      = 1'b0;
        parity_set     = 1'b0;
        if (tick) begin
            rx_os_cnt_nxt = rx_os_end ? '0 : rx_os_cnt + OS_W'(1);
        end
        case (rx_state)
            RX_IDLE: begin
                rx_os_cnt_nxt  = '0;
                rx_bit_cnt_nxt = '0;
                if (rx_fall) begin
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: re-check the line to reject glitches, then align to mid-bit.
                if (rx_half_end) begin
                    rx_os_cnt_nxt = '0;
                    rx_state_nxt  = rx_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_os_end) begin
                    rx_shreg_nxt   = {rx_sync2, rx_shreg[DATA_BITS-1:1]};
                    rx_bit_cnt_nxt = rx_bit_cnt + BIT_W'(1);
                    if (rx_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        rx_state_nxt = PAR_EN ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_os_end) begin
                    parity_set   = ((^rx_shreg) ^ PAR_ODD) != rx_sync2;
                    rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_os_end) begin
                    if (rx_sync2) begin
                        rx_push      = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        frame_set    = 1'b1;
                        rx_state_nxt = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_os_cnt_nxt = '0;
                if (rx_sync2) begin
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk_int),
        .rst     (uart_reset),
        .in_vld  (rx_push),
        .in_dat  (rx_shreg),
        .in_rdy  (fifo_in_rdy),
        .out_vld (uart_rx_valid),
        .out_dat (uart_rx_data),
        .out_rdy (uart_rx_ready)
    );

    assign overflow_set = rx_push && !fifo_in_rdy;

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            uart_rx_frame_err  <= 1'b0;
            uart_rx_parity_err <= 1'b0;
            uart_rx_overflow   <= 1'b0;
        end else begin
            uart_rx_frame_err  <= frame_set    || (uart_rx_frame_err  && !uart_err_clear);
            uart_rx_parity_err <= parity_set   || (uart_rx_parity_err && !uart_err_clear);
            uart_rx_overflow   <= overflow_set || (uart_rx_overflow   && !uart_err_clear);
        end
    end
endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
// Directed bench for uart_rx_tx_fifo: one no-parity instance and one even-parity instance.
// Expected RX words are queued on stimulus and compared on pop.

module tb_uart_rx_tx_fifo;
    localparam int BIT = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // instance A: no parity
    logic [1:0] freq;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, tx_out, rx_in, rx_drv, lb;
    logic       rx_valid, rx_ready, ferr, perr, ovf, err_clr;
    // instance B: even parity
    logic [1:0] p_freq;
    logic [7:0] p_tx_data, p_rx_data;
    logic       p_tx_valid, p_tx_ready, p_tx_out, p_rx_in, p_rx_drv, p_lb;
    logic       p_rx_valid, p_rx_ready, p_ferr, p_perr, p_ovf, p_err_clr;

    assign rx_in   = lb   ? tx_out   : rx_drv;
    assign p_rx_in = p_lb ? p_tx_out : p_rx_drv;

    uart_rx_tx_fifo dut (
        .clk_int(clk), .uart_reset(rst), .freq_control(freq),
        .uart_tx_data(tx_data), .uart_tx_valid(tx_valid), .uart_tx_ready(tx_ready),
        .uart_tx_d_out(tx_out), .uart_rx_d_in(rx_in), .uart_rx_data(rx_data),
        .uart_rx_valid(rx_valid), .uart_rx_ready(rx_ready), .uart_rx_frame_err(ferr),
        .uart_rx_parity_err(perr), .uart_rx_overflow(ovf), .uart_err_clear(err_clr)
    );

    uart_rx_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk_int(clk), .uart_reset(rst), .freq_control(p_freq),
        .uart_tx_data(p_tx_data), .uart_tx_valid(p_tx_valid), .uart_tx_ready(p_tx_ready),
        .uart_tx_d_out(p_tx_out), .uart_rx_d_in(p_rx_in), .uart_rx_data(p_rx_data),
        .uart_rx_valid(p_rx_valid), .uart_rx_ready(p_rx_ready), .uart_rx_frame_err(p_ferr),
        .uart_rx_parity_err(p_perr), .uart_rx_overflow(p_ovf), .uart_err_clear(p_err_clr)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit b, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(b ? p_tx_ready : tx_ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", 32'(b ? p_tx_ready : tx_ready), 32'd1);
        if (b) begin
            p_tx_data  = d;
            p_tx_valid = 1'b1;
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        tx_valid   = 1'b0;
        p_tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input bit b, input int bound, output int cyc);
        cyc = 0;
        while (!(b ? p_rx_valid : rx_valid) && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk("rx_valid_wait", 32'(b ? p_rx_valid : rx_valid), 32'd1);
    endtask

    task automatic pop(input bit b);
        logic [7:0] e;
        @(negedge clk);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("rx_valid_at_pop", 32'(b ? p_rx_valid : rx_valid), 32'd1);
        chk("rx_data", 32'(b ? p_rx_data : rx_data), 32'(e));
        if (b) p_rx_ready = 1'b1;
        else   rx_ready   = 1'b1;
        @(posedge clk);
        #1;
        rx_ready   = 1'b0;
        p_rx_ready = 1'b0;
    endtask

    task automatic drive_bit(input bit b, input logic v);
        if (b) p_rx_drv = v;
        else   rx_drv   = v;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic inject(input bit b, input logic [7:0] d, input bit par_en, input bit par, input bit stop);
        drive_bit(b, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b, d[i]);
        if (par_en) drive_bit(b, par);
        drive_bit(b, stop);
        drive_bit(b, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int         lat, lowc, hic, c;
        logic [7:0] t3 [5];
        t3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst = 1'b1;
        freq = 2'b11;  tx_data = '0;   tx_valid = 1'b0;   rx_drv = 1'b1;   lb = 1'b0;
        rx_ready = 1'b0;   err_clr = 1'b0;
        p_freq = 2'b11; p_tx_data = '0; p_tx_valid = 1'b0; p_rx_drv = 1'b1; p_lb = 1'b0;
        p_rx_ready = 1'b0; p_err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_tx_out",   32'(tx_out), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data",  32'(rx_data), 32'd0);
        chk("rst_flags",    32'({ferr, perr, ovf}), 32'd0);
        chk("rst_p_tx_out", 32'(p_tx_out), 32'd1);

        // loopback 0xA5 at DIV=10
        lb = 1'b1;
        send(1'b0, 8'hA5);
        exp_q.push_back(8'hA5);
        wait_rx(1'b0, 3000, lat);
        chk("t1_latency_in_range", 32'(lat >= 1480 && lat <= 1620), 32'd1);
        chk("t1_flags", 32'({ferr, perr, ovf}), 32'd0);
        pop(1'b0);

        // five back-to-back words into a 4-deep FIFO
        for (int i = 0; i < 5; i++) begin
            send(1'b0, t3[i]);
            if (i < 4) exp_q.push_back(t3[i]);
        end
        repeat (1800) @(negedge clk);
        chk("t3_overflow", 32'(ovf), 32'd1);
        chk("t3_other_flags", 32'({ferr, perr}), 32'd0);
        for (int i = 0; i < 4; i++) pop(1'b0);
        @(negedge clk);
        chk("t3_empty_after_pops", 32'(rx_valid), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_overflow_cleared", 32'(ovf), 32'd0);

        // 0x00 at DIV=120: measure low and stop durations
        lb = 1'b0;
        rx_drv = 1'b1;
        freq = 2'b00;
        repeat (5) @(negedge clk);
        send(1'b0, 8'h00);
        lowc = 0;
        hic  = 0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (tx_out == 1'b0) lowc++;
            else if (tx_ready) break;
            else if (lowc > 0) hic++;
        end
        chk("t2_low_cycles_in_range", 32'(lowc >= 17161 && lowc <= 17280), 32'd1);
        chk("t2_stop_cycles", 32'(hic), 32'd1920);
        chk("t2_ready_after_frame", 32'(tx_ready), 32'd1);

        // stop bit low -> frame error, no push
        freq = 2'b11;
        repeat (5) @(negedge clk);
        inject(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("t4_frame_err", 32'(ferr), 32'd1);
        chk("t4_no_push", 32'(rx_valid), 32'd0);
        chk("t4_no_parity_err", 32'(perr), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_frame_err_cleared", 32'(ferr), 32'd0);

        // glitch shorter than half a bit, then a good frame
        rx_drv = 1'b0;
        repeat (40) @(posedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        chk("t5_no_push", 32'(rx_valid), 32'd0);
        chk("t5_no_flags", 32'({ferr, perr, ovf}), 32'd0);
        inject(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'h5A);
        wait_rx(1'b0, 400, c);
        pop(1'b0);

        // even parity instance: line bits and loopback
        p_lb = 1'b1;
        send(1'b1, 8'h07);
        exp_q.push_back(8'h07);
        c = 0;
        while (p_tx_out != 1'b0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        repeat (3 * BIT + 80) @(negedge clk);
        chk("t6_data_bit2", 32'(p_tx_out), 32'd1);
        repeat (BIT) @(negedge clk);
        chk("t6_data_bit3", 32'(p_tx_out), 32'd0);
        repeat (5 * BIT) @(negedge clk);
        chk("t6_parity_bit", 32'(p_tx_out), 32'd1);
        wait_rx(1'b1, 1000, c);
        chk("t6_loopback_parity_ok", 32'(p_perr), 32'd0);
        pop(1'b1);

        // bad parity: still pushed, flag set
        p_lb = 1'b0;
        inject(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        exp_q.push_back(8'h07);
        wait_rx(1'b1, 400, c);
        chk("t6_parity_err", 32'(p_perr), 32'd1);
        chk("t6_no_frame_err", 32'(p_ferr), 32'd0);
        chk("t6_head_word", 32'(p_rx_data), 32'(exp_q[0]));

        // reset in the middle of a frame
        p_lb = 1'b1;
        send(1'b1, 8'hC3);
        repeat (500) @(negedge clk);
        chk("t6_mid_frame_busy", 32'(p_tx_ready), 32'd0);
        do_reset();
        exp_q.delete();
        chk("t6_rst_tx_out",   32'(p_tx_out), 32'd1);
        chk("t6_rst_tx_ready", 32'(p_tx_ready), 32'd1);
        chk("t6_rst_rx_valid", 32'(p_rx_valid), 32'd0);
        chk("t6_rst_rx_data",  32'(p_rx_data), 32'd0);
        chk("t6_rst_flags",    32'({p_ferr, p_perr, p_ovf}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
